// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall/flush controller for the 5-stage RV pipeline.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MDU_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  imem_ready,
  output logic                  pc_en,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_hold,
  output logic                  mdu_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [7:0] MDU_LIMIT  = 8'(MDU_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] mdu_cnt_q, mdu_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use;

  // x0 is hard-wired zero, so a load targeting it can never create a RAW hazard.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      mdu_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mdu_cnt_d   = mdu_cnt_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      ST_RUN: begin
        if (ex_redirect) begin
          if (FLUSH_CYCLES > 0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else if (ex_mdu_start) begin
          state_d   = ST_MDU_WAIT;
          mdu_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (ex_redirect) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q <= 4'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          if (mdu_cnt_q != MDU_LIMIT) mdu_cnt_d = mdu_cnt_q + 8'd1;
          if (mdu_cnt_d == MDU_LIMIT) timeout_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
        mdu_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mdu_start) begin
            pc_en      = 1'b0;
            if_id_hold = 1'b1;
            ex_hold    = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = ex_redirect;
        end
        ST_MDU_WAIT: begin
          if (!mdu_done) begin
            pc_en      = 1'b0;
            if_id_hold = 1'b1;
            ex_hold    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      if (!pc_en)      stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush) flush_cyc_q <= flush_cyc_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cyc_q;
`else
  // Performance counters are compiled out; control behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl plus hand-written
// multi-cycle sequences for MDU timeout and asynchronous reset.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read;
  logic       ex_redirect, ex_mdu_start, mdu_done, imem_ready;

  logic pc_en, if_id_hold, if_id_flush, id_ex_flush, ex_hold, mdu_timeout;
  logic pc_en2, if_id_hold2, if_id_flush2, id_ex_flush2, ex_hold2, mdu_timeout2;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles, stall_cycles2, flush_cycles2;
`endif

  // Main instance: two bubble cycles after a redirect, long MDU limit.
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .MDU_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .imem_ready(imem_ready),
    .pc_en(pc_en), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .mdu_timeout(mdu_timeout)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  // Short-timeout instance used for the sticky timeout sequence.
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .MDU_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .imem_ready(imem_ready),
    .pc_en(pc_en2), .if_id_hold(if_id_hold2), .if_id_flush(if_id_flush2),
    .id_ex_flush(id_ex_flush2), .ex_hold(ex_hold2), .mdu_timeout(mdu_timeout2)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles2), .flush_cycles(flush_cycles2)
`endif
  );

  always #5 clk = ~clk;

  // Output bundle: {pc_en, if_id_hold, if_id_flush, id_ex_flush, ex_hold, mdu_timeout}
  logic [5:0] outs, outs2;
  assign outs  = {pc_en, if_id_hold, if_id_flush, id_ex_flush, ex_hold, mdu_timeout};
  assign outs2 = {pc_en2, if_id_hold2, if_id_flush2, id_ex_flush2, ex_hold2, mdu_timeout2};

  localparam logic [5:0] RUN_O   = 6'b100000;
  localparam logic [5:0] LU_O    = 6'b010100;
  localparam logic [5:0] REDIR_O = 6'b101100;
  localparam logic [5:0] FLUSH_O = 6'b101000;
  localparam logic [5:0] MDU_O   = 6'b010010;
  localparam logic [5:0] IMEM_O  = 6'b001000;
  localparam logic [5:0] RST_O   = 6'b001100;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       ms;
    logic       md;
    logic       ir;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic mr, input logic redir, input logic ms,
                     input logic md, input logic ir, input logic [5:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.redir = redir; v.ms = ms; v.md = md; v.ir = ir; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b (pc_en,hold,if_flush,idex_flush,ex_hold,timeout)",
               name, act, exp);
    else
      n_pass++;
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.redir;
    ex_mdu_start = v.ms; mdu_done = v.md; imem_ready = v.ir;
    #1;
  endtask

  task automatic idle_in(input logic ms, input logic md);
    vec_t v;
    v.name = ""; v.rs1 = '0; v.rs2 = '0; v.u1 = 0; v.u2 = 0; v.rd = '0;
    v.mr = 0; v.redir = 0; v.ms = ms; v.md = md; v.ir = 1; v.exp = '0;
    apply(v);
  endtask

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = '0; ex_mem_read = 0; ex_redirect = 0; ex_mdu_start = 0;
    mdu_done = 0; imem_ready = 1;

    //    name            rs1 rs2 u1 u2 rd mr rdr ms md ir  expected
    add("idle",           0,  0,  0, 0, 0, 0, 0,  0, 0, 1, RUN_O);
    add("lu_rs2",         0,  5,  0, 1, 5, 1, 0,  0, 0, 1, LU_O);
    add("lu_release",     0,  0,  0, 0, 0, 0, 0,  0, 0, 1, RUN_O);
    add("lu_rs1",         7,  0,  1, 0, 7, 1, 0,  0, 0, 1, LU_O);
    add("lu_rd_x0",       0,  0,  1, 1, 0, 1, 0,  0, 0, 1, RUN_O);
    add("lu_unused_src",  0,  5,  0, 0, 5, 1, 0,  0, 0, 1, RUN_O);
    add("no_load",        5,  0,  1, 0, 5, 0, 0,  0, 0, 1, RUN_O);
    add("imem_stall",     0,  0,  0, 0, 0, 0, 0,  0, 0, 0, IMEM_O);
    add("redir_priority", 0,  3,  0, 1, 3, 1, 1,  1, 0, 0, REDIR_O);
    add("flush_c1",       0,  0,  0, 0, 0, 0, 0,  0, 0, 0, FLUSH_O);
    add("flush_c2",       0,  3,  0, 1, 3, 1, 0,  0, 0, 1, FLUSH_O);
    add("flush_exit",     0,  0,  0, 0, 0, 0, 0,  0, 0, 1, RUN_O);
    add("mdu_priority",   4,  0,  1, 0, 4, 1, 0,  1, 0, 0, MDU_O);
    add("mdu_wait1",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, MDU_O);
    add("mdu_wait2_rdr",  0,  0,  0, 0, 0, 0, 1,  0, 0, 1, MDU_O);
    add("mdu_wait3_ms",   0,  0,  0, 0, 0, 0, 0,  1, 0, 1, MDU_O);
    add("mdu_wait4",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, MDU_O);
    add("mdu_done",       0,  0,  0, 0, 0, 0, 0,  0, 1, 1, RUN_O);
    add("after_mdu",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, RUN_O);
    add("redir2",         0,  0,  0, 0, 0, 0, 1,  0, 0, 1, REDIR_O);
    add("flush2_c1",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, FLUSH_O);
    add("redir_in_flush", 0,  0,  0, 0, 0, 0, 1,  0, 0, 1, REDIR_O);
    add("reload_c1",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, FLUSH_O);
    add("reload_c2",      0,  0,  0, 0, 0, 0, 0,  0, 0, 1, FLUSH_O);
    add("reload_exit",    0,  0,  0, 0, 0, 0, 0,  0, 0, 1, RUN_O);

    // Reset state, observed while the clock is running.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs, RST_O);
    check("reset_outputs_to", outs2, RST_O);
    @(negedge clk);
    rst = 1'b0;
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      check(tbl[i].name, outs, tbl[i].exp);
    end

    // Sticky MDU timeout on the MDU_TIMEOUT=4 instance.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("to_reset_clears", outs2, RST_O);
    @(negedge clk);
    rst = 1'b0;
    idle_in(1'b1, 1'b0);
    check("to_start", outs2, MDU_O);
    for (int c = 1; c <= 4; c++) begin
      idle_in(1'b0, 1'b0);
      check($sformatf("to_wait%0d", c), outs2, MDU_O);
    end
    idle_in(1'b0, 1'b0);
    check("to_flag_set", outs2, 6'b010011);
    idle_in(1'b0, 1'b1);
    check("to_done_sticky", outs2, 6'b100001);
    idle_in(1'b0, 1'b0);
    check("to_still_sticky", outs2, 6'b100001);
    check("main_no_timeout", outs, RUN_O);

    // Asynchronous reset raised in the middle of an MDU wait.
    idle_in(1'b1, 1'b0);
    check("arst_mdu_start", outs, MDU_O);
    idle_in(1'b0, 1'b0);
    check("arst_mdu_wait", outs, MDU_O);
    #1;
    rst = 1'b1;
    #1;
    check("arst_immediate", outs, RST_O);
    check("arst_timeout_clr", outs2, RST_O);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_run", outs, RUN_O);
    idle_in(1'b0, 1'b0);
    check("arst_run_next", outs, RUN_O);
    check("arst_run_next_to", outs2, RUN_O);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
